// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types for the hazard scoreboard unit: instruction classes,
// forward-select codes, control FSM states and the record-pipe entry.
package hazard_scoreboard_unit_pkg;

  // Record entries hold the destination index zero-extended to this width,
  // so register files of up to 256 entries are supported.
  localparam int REC_RW = 8;

  // A countdown of 15 marks a divide writer; it only clears on div_done.
  localparam logic [3:0] DIV_CNT = 4'd15;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_MUL    = 3'd4,
    CLS_DIV    = 3'd5
  } cls_e;

  typedef enum logic [1:0] {
    FWD_RF       = 2'd0,
    FWD_EXE_ALU  = 2'd1,
    FWD_MEM_ALU  = 2'd2,
    FWD_MEM_LOAD = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_DIVWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REC_RW-1:0] rd;
    cls_e              cls;
  } rec_t;

  // Unused encodings 6 and 7 behave as ALU operations.
  function automatic cls_e decode_class(input logic [2:0] raw);
    cls_e c;
    case (raw)
      3'd1:    c = CLS_LOAD;
      3'd2:    c = CLS_STORE;
      3'd3:    c = CLS_BRANCH;
      3'd4:    c = CLS_MUL;
      3'd5:    c = CLS_DIV;
      default: c = CLS_ALU;
    endcase
    return c;
  endfunction

  // Stores and branches carry no destination register.
  function automatic logic writes_rd(input cls_e c);
    return (c == CLS_ALU) || (c == CLS_LOAD) || (c == CLS_MUL) || (c == CLS_DIV);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage request / pipeline-control bundle of the hazard scoreboard unit.
// master: the pipeline side driving the ID instruction; slave: the unit.
interface hazard_scoreboard_unit_if #(
  parameter int RW = 5
);
  logic          id_valid;
  logic          rs1use_ID;
  logic          rs2use_ID;
  logic [RW-1:0] rs1_ID;
  logic [RW-1:0] rs2_ID;
  logic [RW-1:0] rd_ID;
  logic [2:0]    class_ID;
  logic          redirect_EXE;
  logic          div_done;

  logic          PC_EN_IF;
  logic          reg_FD_EN;
  logic          reg_DE_flush;
  logic          reg_FD_flush;
  logic [1:0]    forward_ctrl_A;
  logic [1:0]    forward_ctrl_B;
  logic          issue_ID;
  logic          div_busy;

  modport master (
    output id_valid, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, class_ID,
           redirect_EXE, div_done,
    input  PC_EN_IF, reg_FD_EN, reg_DE_flush, reg_FD_flush,
           forward_ctrl_A, forward_ctrl_B, issue_ID, div_busy
  );

  modport slave (
    input  id_valid, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, class_ID,
           redirect_EXE, div_done,
    output PC_EN_IF, reg_FD_EN, reg_DE_flush, reg_FD_flush,
           forward_ctrl_A, forward_ctrl_B, issue_ID, div_busy
  );
endinterface

// File: rtl/hazard_reg_scoreboard.sv
// Per-register pending-write countdowns with combinational lookups for the
// two source operands and the destination (multi-cycle writer check).
module hazard_reg_scoreboard
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int MUL_LAT = 3,
  parameter int RW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [RW-1:0] i_set_rd,
  input  cls_e          i_set_cls,
  input  logic          i_div_done,
  input  logic [RW-1:0] i_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic [RW-1:0] i_rd,
  output logic          o_rs1_pend,
  output logic          o_rs2_pend,
  output logic          o_rd_long_pend
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  logic [3:0] r_cnt  [NREG];
  logic       r_long [NREG];
  logic [3:0] w_set_cnt;
  logic       w_set_long;

  // Initial countdown for the issuing writer: cycles until its result can be forwarded.
  always_comb begin
    w_set_cnt  = 4'd0;
    w_set_long = 1'b0;
    case (i_set_cls)
      CLS_LOAD: w_set_cnt = 4'd1;
      CLS_MUL: begin
        w_set_cnt  = MUL_CNT;
        w_set_long = 1'b1;
      end
      CLS_DIV: begin
        w_set_cnt  = DIV_CNT;
        w_set_long = 1'b1;
      end
      default: w_set_cnt = 4'd0;
    endcase
  end

  // Countdown update; x0 is never written so it always reads as not pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i]  <= 4'd0;
        r_long[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (i_set && (i_set_rd == RW'(i))) begin
          r_cnt[i]  <= w_set_cnt;
          r_long[i] <= w_set_long;
        end else if (r_cnt[i] == DIV_CNT) begin
          if (i_div_done) begin
            r_cnt[i]  <= 4'd0;
            r_long[i] <= 1'b0;
          end
        end else if (r_cnt[i] != 4'd0) begin
          r_cnt[i] <= r_cnt[i] - 4'd1;
        end
      end
    end
  end

  assign o_rs1_pend     = (i_rs1 != '0) && (r_cnt[i_rs1] != 4'd0);
  assign o_rs2_pend     = (i_rs2 != '0) && (r_cnt[i_rs2] != 4'd0);
  assign o_rd_long_pend = (i_rd  != '0) && (r_cnt[i_rd]  != 4'd0) && r_long[i_rd];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard unit: RAW/WAW stall detection, divider occupancy,
// redirect flushing and operand forward selection for an in-order pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int MUL_LAT   = 3,
  parameter int FWD_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_scoreboard_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);

  localparam int RW = $clog2(NREG);

  state_e r_state;
  rec_t   r_rec [FWD_DEPTH];
  logic   r_div_busy;

  cls_e   w_cls;
  logic   w_writes;
  logic   w_rs1_pend, w_rs2_pend, w_rd_long_pend;
  logic   w_hazard, w_div_struct, w_stall, w_redirect, w_issue;
  rec_t   w_new_rec;
  fwd_e   w_fwd_a, w_fwd_b;

  // A record supplies a forward only if it writes a real (non-x0) register.
  function automatic logic rec_match(input rec_t r, input logic [RW-1:0] rs);
    return r.valid && writes_rd(r.cls) && (rs != '0) && (r.rd == REC_RW'(rs));
  endfunction

  // Forward source offered by a record at the given depth (0 = EXE, 1 = MEM).
  function automatic fwd_e stage_sel(input int stage, input cls_e c);
    fwd_e f;
    f = FWD_RF;
    if (stage == 0) begin
      if ((c == CLS_ALU) || ((c == CLS_MUL) && (MUL_LAT == 1))) f = FWD_EXE_ALU;
    end else if (stage == 1) begin
      if ((c == CLS_ALU) || ((c == CLS_MUL) && (MUL_LAT <= 2))) f = FWD_MEM_ALU;
      else if (c == CLS_LOAD)                                     f = FWD_MEM_LOAD;
    end
    return f;
  endfunction

  assign w_cls    = decode_class(bus.class_ID);
  assign w_writes = writes_rd(w_cls);

  hazard_reg_scoreboard #(
    .NREG    (NREG),
    .MUL_LAT (MUL_LAT),
    .RW      (RW)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_set          (w_issue && w_writes),
    .i_set_rd       (bus.rd_ID),
    .i_set_cls      (w_cls),
    .i_div_done     (bus.div_done),
    .i_rs1          (bus.rs1_ID),
    .i_rs2          (bus.rs2_ID),
    .i_rd           (bus.rd_ID),
    .o_rs1_pend     (w_rs1_pend),
    .o_rs2_pend     (w_rs2_pend),
    .o_rd_long_pend (w_rd_long_pend)
  );

  // The stall decision is combinational so a dependent instruction waits
  // exactly as long as its producer's countdown; the STALL state records
  // that the previous cycle stalled, while DIVWAIT holds until div_done.
  assign w_hazard     = bus.id_valid &&
                        ((bus.rs1use_ID && w_rs1_pend) ||
                         (bus.rs2use_ID && w_rs2_pend) ||
                         (w_writes && w_rd_long_pend));
  assign w_div_struct = bus.id_valid && (w_cls == CLS_DIV) && r_div_busy;
  assign w_stall      = w_hazard || w_div_struct || (r_state == ST_DIVWAIT);
  // Redirect is masked while in reset so the flushes read 0 there.
  assign w_redirect   = bus.redirect_EXE && rst_n;
  assign w_issue      = bus.id_valid && !w_stall && !w_redirect;

  assign bus.PC_EN_IF     = w_redirect || !w_stall;
  assign bus.reg_FD_EN    = w_redirect || !w_stall;
  assign bus.reg_DE_flush = w_redirect || w_stall;
  assign bus.reg_FD_flush = w_redirect;
  assign bus.issue_ID     = w_issue;
  assign bus.div_busy     = r_div_busy;

  // Entry pushed into the record pipe: the issuing instruction or a bubble.
  always_comb begin
    w_new_rec = '0;
    if (w_issue) begin
      w_new_rec.valid = 1'b1;
      w_new_rec.rd    = REC_RW'(bus.rd_ID);
      w_new_rec.cls   = w_cls;
    end
  end

  // Forward select per operand; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (rec_match(r_rec[i], bus.rs1_ID)) w_fwd_a = stage_sel(i, r_rec[i].cls);
      if (rec_match(r_rec[i], bus.rs2_ID)) w_fwd_b = stage_sel(i, r_rec[i].cls);
    end
  end

  assign bus.forward_ctrl_A = w_fwd_a;
  assign bus.forward_ctrl_B = w_fwd_b;

  // Record pipe shifts every cycle, loading the ID instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FWD_DEPTH; i++) r_rec[i] <= '0;
    end else begin
      r_rec[0] <= w_new_rec;
      for (int i = 1; i < FWD_DEPTH; i++) r_rec[i] <= r_rec[i-1];
    end
  end

  // Divider occupancy: a new divide issue wins over a same-cycle completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_busy <= 1'b0;
    end else if (w_issue && (w_cls == CLS_DIV)) begin
      r_div_busy <= 1'b1;
    end else if (bus.div_done) begin
      r_div_busy <= 1'b0;
    end
  end

  // Control FSM; a redirect pre-empts every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (w_redirect) begin
      r_state <= ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL: begin
          if (w_hazard)          r_state <= ST_STALL;
          else if (w_div_struct) r_state <= ST_DIVWAIT;
          else                   r_state <= ST_RUN;
        end
        ST_DIVWAIT: if (bus.div_done) r_state <= ST_RUN;
        default:    r_state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Free-running, wrapping event counters for stalled cycles and redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (w_stall && !w_redirect) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect)             r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule
